// File: rtl/dram_bridge.sv
// Bridges single-beat record requests to an AXI4-Lite master port (one request at a time).
// Optional macro DRAM_BYTE_SWAP_EN byte-reverses both data paths for a little-endian DRAM image.
module dram_bridge #(
    parameter logic [16:0] BASE_ADDR = 17'h10000,
    parameter int          ID_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] C_addr,
    input  logic [63:0]     C_data_w,
    input  logic            C_in_valid,
    input  logic            C_r_wb,
    output logic            C_out_valid,
    output logic [63:0]     C_data_r,
    output logic            AR_VALID,
    output logic [16:0]     AR_ADDR,
    input  logic            AR_READY,
    input  logic            R_VALID,
    input  logic [63:0]     R_DATA,
    input  logic [1:0]      R_RESP,
    output logic            R_READY,
    output logic            AW_VALID,
    output logic [16:0]     AW_ADDR,
    input  logic            AW_READY,
    output logic            W_VALID,
    output logic [63:0]     W_DATA,
    input  logic            W_READY,
    input  logic            B_VALID,
    input  logic [1:0]      B_RESP,
    output logic            B_READY
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam int SUM_W = (ID_W + 3 > 17) ? ID_W + 3 : 17;

    logic [2:0]       state_reg, state_next;
    logic [SUM_W-1:0] addr_sum;
    logic [16:0]      req_addr;
    logic [63:0]      rd_data_in;
    logic [63:0]      wr_data_out;
    logic             accept;
    logic             resp_unused;

    logic        c_out_valid_reg;
    logic [63:0] c_data_r_reg;
    logic        ar_valid_reg;
    logic [16:0] ar_addr_reg;
    logic        r_ready_reg;
    logic        aw_valid_reg;
    logic [16:0] aw_addr_reg;
    logic        w_valid_reg;
    logic [63:0] w_data_reg;
    logic        b_ready_reg;

    // Response codes carry no meaning for this client; they are deliberately dropped.
    assign resp_unused = ^{R_RESP, B_RESP};

    assign addr_sum = SUM_W'(BASE_ADDR) + SUM_W'({C_addr, 3'b000});
    assign req_addr = addr_sum[16:0];
    assign accept   = (state_reg == IDLE) && C_in_valid;

`ifdef DRAM_BYTE_SWAP_EN
    for (genvar gi = 0; gi < 8; gi++) begin : g_swap
        assign rd_data_in[gi*8 +: 8]  = R_DATA[(7-gi)*8 +: 8];
        assign wr_data_out[gi*8 +: 8] = C_data_w[(7-gi)*8 +: 8];
    end
`else
    assign rd_data_in  = R_DATA;
    assign wr_data_out = C_data_w;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (C_in_valid) state_next = C_r_wb ? RD_ADDR : WR_REQ;
            RD_ADDR: if (AR_READY) state_next = RD_DATA;
            RD_DATA: if (R_VALID) state_next = DONE;
            // Each channel counts as done once its valid has dropped or is being accepted now.
            WR_REQ:  if ((!aw_valid_reg || AW_READY) && (!w_valid_reg || W_READY))
                         state_next = WR_RESP;
            WR_RESP: if (B_VALID) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            c_out_valid_reg <= 1'b0;
            c_data_r_reg    <= '0;
            ar_valid_reg    <= 1'b0;
            ar_addr_reg     <= '0;
            r_ready_reg     <= 1'b0;
            aw_valid_reg    <= 1'b0;
            aw_addr_reg     <= '0;
            w_valid_reg     <= 1'b0;
            w_data_reg      <= '0;
            b_ready_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Flags decoded from the next state keep every handshake output registered.
            c_out_valid_reg <= (state_next == DONE);
            ar_valid_reg    <= (state_next == RD_ADDR);
            r_ready_reg     <= (state_next == RD_DATA);
            b_ready_reg     <= (state_next == WR_RESP);

            if (accept && C_r_wb) begin
                ar_addr_reg <= req_addr;
            end

            if (accept && !C_r_wb) begin
                aw_valid_reg <= 1'b1;
                w_valid_reg  <= 1'b1;
                aw_addr_reg  <= req_addr;
                w_data_reg   <= wr_data_out;
            end else begin
                if (AW_READY) aw_valid_reg <= 1'b0;
                if (W_READY)  w_valid_reg  <= 1'b0;
            end

            if ((state_reg == RD_DATA) && R_VALID) begin
                c_data_r_reg <= rd_data_in;
            end
        end
    end

    assign C_out_valid = c_out_valid_reg;
    assign C_data_r    = c_data_r_reg;
    assign AR_VALID    = ar_valid_reg;
    assign AR_ADDR     = ar_addr_reg;
    assign R_READY     = r_ready_reg;
    assign AW_VALID    = aw_valid_reg;
    assign AW_ADDR     = aw_addr_reg;
    assign W_VALID     = w_valid_reg;
    assign W_DATA      = w_data_reg;
    assign B_READY     = b_ready_reg;

endmodule
